// File: rtl/regfile_dump_pkg.sv
// Shared register-file constants for the debug dump engine.
// These mirror the CPU-wide register file geometry so parameter defaults track it.
package regfile_dump_pkg;

  localparam int REG_W  = 16;
  localparam int REG_AW = 4;
  localparam int REG_N  = 16;

endpackage

// File: rtl/regfile_dump_csum_acc.sv
// Modular checksum accumulator: adds each accepted word, carry out of the top bit dropped.
// Synchronous clear for the start of a dump, asynchronous active-low reset.
module regfile_dump_csum_acc
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH = REG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sum
);

  // Running sum register; clear has priority over a same-cycle add.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (enable) begin
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks FIRST_REG..LAST_REG through one register-file
// read port and streams each value over a valid/ready handshake, optionally
// followed by a checksum word. busy tells the control unit to leave the read port alone.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int WIDTH     = REG_W,
  parameter int AW        = REG_AW,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = REG_N - 1,
  parameter int EMIT_CSUM = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [AW-1:0]    ra,
  input  logic [WIDTH-1:0] rd,
  output logic             busy,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done
);

  // A reversed or out-of-range address window is a configuration mistake.
  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG >= (1 << AW)) begin : g_badRange
    $error("regfile_dump: need 0 <= FIRST_REG <= LAST_REG < 2**AW");
  end

  localparam logic [AW-1:0] FIRST_ADDR = AW'(FIRST_REG);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(LAST_REG);
  localparam logic          EMIT       = (EMIT_CSUM != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    CSUM = 2'd3
  } state_t;

  state_t            stateReg;
  state_t            stateNext;
  logic [AW-1:0]     addrReg;
  logic [AW-1:0]     addrNext;
  logic [WIDTH-1:0]  dataReg;
  logic [WIDTH-1:0]  dataNext;
  logic [AW-1:0]     addrOutReg;
  logic [AW-1:0]     addrOutNext;
  logic              lastReg;
  logic              lastNext;
  logic              doneReg;
  logic              doneNext;
  logic              csumClear;
  logic              csumEnable;
  logic [WIDTH-1:0]  csumValue;
  logic              atLastAddr;

  assign atLastAddr = (addrReg == LAST_ADDR);

  // Checksum covers exactly the captured register words that the sink accepted.
  regfile_dump_csum_acc #(
    .WIDTH(WIDTH)
  ) u_csum (
    .clk    (clk),
    .reset  (reset),
    .clear  (csumClear),
    .enable (csumEnable),
    .data   (dataReg),
    .sum    (csumValue)
  );

  // State, address counter and the registered output word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg   <= IDLE;
      addrReg    <= '0;
      dataReg    <= '0;
      addrOutReg <= '0;
      lastReg    <= 1'b0;
      doneReg    <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      addrReg    <= addrNext;
      dataReg    <= dataNext;
      addrOutReg <= addrOutNext;
      lastReg    <= lastNext;
      doneReg    <= doneNext;
    end
  end

  // Next-state logic: one READ cycle per register, then hold SEND until accepted.
  always_comb begin
    stateNext   = stateReg;
    addrNext    = addrReg;
    dataNext    = dataReg;
    addrOutNext = addrOutReg;
    lastNext    = lastReg;
    doneNext    = 1'b0;
    csumClear   = 1'b0;
    csumEnable  = 1'b0;
    case (stateReg)
      IDLE: begin
        // A start landing on the done cycle belongs to the dump just finished.
        if (start && !doneReg) begin
          addrNext  = FIRST_ADDR;
          csumClear = 1'b1;
          stateNext = READ;
        end
      end
      READ: begin
        dataNext    = rd;
        addrOutNext = addrReg;
        lastNext    = atLastAddr && !EMIT;
        stateNext   = SEND;
      end
      SEND: begin
        if (out_ready) begin
          csumEnable = 1'b1;
          if (atLastAddr) begin
            if (EMIT) begin
              addrOutNext = '1;
              lastNext    = 1'b1;
              stateNext   = CSUM;
            end else begin
              addrOutNext = '0;
              lastNext    = 1'b0;
              doneNext    = 1'b1;
              stateNext   = IDLE;
            end
          end else begin
            addrNext  = addrReg + 1'b1;
            stateNext = READ;
          end
        end
      end
      CSUM: begin
        if (out_ready) begin
          addrOutNext = '0;
          lastNext    = 1'b0;
          doneNext    = 1'b1;
          stateNext   = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Outputs: ra stays on the current address through SEND so rd remains coherent.
  always_comb begin
    ra        = (stateReg == IDLE) ? '0 : addrReg;
    busy      = (stateReg != IDLE);
    out_valid = (stateReg == SEND) || (stateReg == CSUM);
    out_data  = (stateReg == CSUM) ? csumValue : dataReg;
    out_addr  = addrOutReg;
    out_last  = lastReg;
    done      = doneReg;
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: a reference model queues the expected
// word stream per dump, and monitors compare every presented word against it.
module tb_regfile_dump;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  addr;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        startOne = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] regs [16];

  logic [3:0]  ra, out_addr, raOne, addrOne;
  logic [15:0] rd, out_data, rdOne, dataOne;
  logic        busy, out_valid, out_last, done;
  logic        busyOne, validOne, lastOne, doneOne;

  int    checks = 0;
  int    errors = 0;
  int    readyMode = 0;
  logic  doneDue0 = 1'b0;
  logic  doneDue1 = 1'b0;
  word_t expQ0[$];
  word_t expQ1[$];

  always #5 clk = ~clk;

  assign rd    = (ra == 4'd0) ? 16'h0000 : regs[ra];
  assign rdOne = (raOne == 4'd0) ? 16'h0000 : regs[raOne];

  regfile_dump dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ra        (ra),
    .rd        (rd),
    .busy      (busy),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .done      (done)
  );

  regfile_dump #(
    .FIRST_REG (0),
    .LAST_REG  (0),
    .EMIT_CSUM (0)
  ) dutOne (
    .clk       (clk),
    .reset     (reset),
    .start     (startOne),
    .ra        (raOne),
    .rd        (rdOne),
    .busy      (busyOne),
    .out_data  (dataOne),
    .out_addr  (addrOne),
    .out_valid (validOne),
    .out_ready (out_ready),
    .out_last  (lastOne),
    .done      (doneOne)
  );

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: the dump is every address in the window in order, R0 reads 0,
  // then the 16-bit wrapping sum of those words at address F.
  function automatic void pushDump(input int which, input int first, input int last, input bit emit);
    word_t       w;
    logic [15:0] sum;
    sum = 16'h0000;
    for (int a = first; a <= last; a++) begin
      w.data = (a == 0) ? 16'h0000 : regs[a];
      w.addr = 4'(a);
      w.last = (a == last) && !emit;
      sum    = sum + w.data;
      if (which == 0) expQ0.push_back(w); else expQ1.push_back(w);
    end
    if (emit) begin
      w.data = sum;
      w.addr = 4'hF;
      w.last = 1'b1;
      if (which == 0) expQ0.push_back(w); else expQ1.push_back(w);
    end
  endfunction

  // Sink ready: 0 = always ready, 1 = random 50%, 2 = stalled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor for the default-parameter instance.
  always @(negedge clk) begin
    word_t w;
    if (!reset) begin
      doneDue0 = 1'b0;
    end else begin
      checkOutput("done0 timing", {31'b0, done}, {31'b0, doneDue0});
      doneDue0 = 1'b0;
      if (out_valid) begin
        if (expQ0.size() == 0) begin
          checkOutput("word0 unexpected", {11'b0, out_data, out_addr, out_last}, 32'hFFFFFFFF);
        end else begin
          w = expQ0[0];
          checkOutput("word0", {11'b0, out_data, out_addr, out_last}, 32'(w));
          if (out_ready) begin
            void'(expQ0.pop_front());
            doneDue0 = w.last;
          end
        end
      end
    end
  end

  // Monitor for the single-register instance.
  always @(negedge clk) begin
    word_t w;
    if (!reset) begin
      doneDue1 = 1'b0;
    end else begin
      checkOutput("done1 timing", {31'b0, doneOne}, {31'b0, doneDue1});
      doneDue1 = 1'b0;
      if (validOne) begin
        if (expQ1.size() == 0) begin
          checkOutput("word1 unexpected", {11'b0, dataOne, addrOne, lastOne}, 32'hFFFFFFFF);
        end else begin
          w = expQ1[0];
          checkOutput("word1", {11'b0, dataOne, addrOne, lastOne}, 32'(w));
          if (out_ready) begin
            void'(expQ1.pop_front());
            doneDue1 = w.last;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int which);
    @(negedge clk);
    if (which == 0) start = 1'b1; else startOne = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    startOne = 1'b0;
  endtask

  // Returns on the negedge of the done cycle, or flags a timeout.
  task automatic waitDone(input int which, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((which == 0) ? done : doneOne) == 1'b0 && n < budget);
    checkOutput("done arrival", {31'b0, ((which == 0) ? done : doneOne)}, 32'd1);
  endtask

  // Waits (bounded) until the main instance sits at address a with the given valid.
  task automatic waitAt(input logic wantValid, input logic [3:0] a, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid == wantValid && ra == a) && n < budget);
    checkOutput("reach address", {27'b0, out_valid, ra}, {27'b0, wantValid, a});
  endtask

  task automatic runDump(input int which, input int first, input int last, input bit emit);
    pushDump(which, first, last, emit);
    applyStimulus(which);
    waitDone(which, 400);
    checkOutput("queue drained", 32'((which == 0) ? expQ0.size() : expQ1.size()), 32'd0);
    checkOutput("busy after done", {31'b0, ((which == 0) ? busy : busyOne)}, 32'd0);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int n = 0; n < 16; n++) regs[n] = 16'h1000 + 16'(n);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset state", {4'b0, ra, busy, out_data, out_addr, out_valid, out_last, done}, 32'd0);
    reset = 1'b1;

    // 1. Ready sink, with first-word latency
    readyMode = 0;
    pushDump(0, 1, 15, 1);
    applyStimulus(0);
    checkOutput("latency N+1", {30'b0, busy, out_valid}, 32'b10);
    @(posedge clk);
    #1;
    checkOutput("latency N+2", {31'b0, out_valid}, 32'd1);
    waitDone(0, 400);
    checkOutput("queue drained", 32'(expQ0.size()), 32'd0);
    checkOutput("busy after done", {31'b0, busy}, 32'd0);

    // 2. Same stream with a randomly stalling sink, then random contents
    readyMode = 1;
    runDump(0, 1, 15, 1);
    for (int n = 0; n < 16; n++) regs[n] = 16'($urandom);
    runDump(0, 1, 15, 1);
    readyMode = 0;

    // 3. Single-register window starting at R0, no checksum
    runDump(1, 0, 0, 0);

    // 4. Checksum carry dropped
    for (int n = 0; n < 16; n++) regs[n] = 16'hFFFF;
    runDump(0, 1, 15, 1);

    // 5. start during SEND and on the done cycle is ignored
    for (int n = 0; n < 16; n++) regs[n] = 16'h1000 + 16'(n);
    pushDump(0, 1, 15, 1);
    applyStimulus(0);
    waitAt(1'b1, 4'd5, 100);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(0, 400);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("start on done ignored", {31'b0, busy}, 32'd0);
    checkOutput("queue drained", 32'(expQ0.size()), 32'd0);
    repeat (3) @(negedge clk);

    // 6. Reset while SEND addr 7 is stalled
    pushDump(0, 1, 15, 1);
    applyStimulus(0);
    waitAt(1'b0, 4'd7, 100);
    readyMode = 2;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset outputs", {4'b0, ra, busy, out_data, out_addr, out_valid, out_last, done}, 32'd0);
    expQ0.delete();
    repeat (3) begin
      @(negedge clk);
      checkOutput("no done in reset", {30'b0, done, out_valid}, 32'd0);
    end
    reset = 1'b1;
    readyMode = 0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("no done after reset", {30'b0, done, busy}, 32'd0);
    readyMode = 1;
    runDump(0, 1, 15, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
